// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the RAM block loader.
// The states, the widths and the RAM read latency live here.
package ram_loader_pkg;

    localparam int LD_ADDR_W  = 8;
    localparam int LD_DATA_W  = 8;
    // A read address takes this many cycles to appear on q; it is covered by RD_WAIT.
    localparam int RD_LATENCY = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WR,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_ACC,
        S_CHECK,
        S_DONE,
        S_FAIL
    } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Single-port RAM bus: address, write data and write enable out; registered read data in.
// The loader drives the bus through the master modport; the RAM uses the slave modport.
interface ram_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport master (output ram_addr, output ram_data, output ram_wren, input ram_q);
    modport slave  (input ram_addr, input ram_data, input ram_wren, output ram_q);
endinterface

// File: rtl/byte_checksum.sv
// Additive checksum (mod 2**W) that can be cleared; the sum updates on the clock edge after add_en.
// There is no backpressure: clr has priority over add_en.
module byte_checksum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Loads a byte stream into RAM from a base address, then reads the block back to check its sum.
// Each write takes 2 cycles; verify takes 3*count+1 cycles. Strobes are pulses, and any that arrive early are dropped and flagged.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = LD_ADDR_W,
    parameter int DATA_W = LD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              wr_strobe,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_load,
    input  logic              abort,
    ram_loader_if.master      ram,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              error,
    output logic              overrun
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] byte_q;
    logic [ADDR_W:0]   idx;
    logic              end_pend;
    logic [DATA_W-1:0] wsum, rsum;

    logic latch_start, take_byte, do_write, set_pend, clr_pend;
    logic start_rd, acc, ovr_set;

    assign full = (count == DEPTH);

    always_comb begin
        state_n     = state;
        latch_start = 1'b0;
        take_byte   = 1'b0;
        do_write    = 1'b0;
        set_pend    = 1'b0;
        clr_pend    = 1'b0;
        start_rd    = 1'b0;
        acc         = 1'b0;
        ovr_set     = 1'b0;
        if (abort) begin
            state_n  = S_IDLE;
            clr_pend = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_n     = S_LOAD;
                        latch_start = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (wr_strobe) begin
                        // A write always wins; a simultaneous end_load waits for the next LOAD cycle.
                        set_pend = end_load;
                        if (full) begin
                            ovr_set = 1'b1;
                        end else begin
                            take_byte = 1'b1;
                            state_n   = S_WR;
                        end
                    end else if (end_load || end_pend) begin
                        clr_pend = 1'b1;
                        if (count == '0) begin
                            state_n = S_DONE;
                        end else begin
                            start_rd = 1'b1;
                            state_n  = S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    do_write = 1'b1;
                    ovr_set  = wr_strobe;
                    set_pend = end_load;
                    state_n  = S_LOAD;
                end
                S_RD_ADDR: state_n = S_RD_WAIT;
                S_RD_WAIT: state_n = S_RD_ACC;
                S_RD_ACC: begin
                    acc     = 1'b1;
                    state_n = ((idx + 1'b1) == count) ? S_CHECK : S_RD_ADDR;
                end
                S_CHECK: state_n = (rsum == wsum) ? S_DONE : S_FAIL;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_WR:                 addr_c = base + count[ADDR_W-1:0];
            S_RD_ADDR, S_RD_WAIT: addr_c = base + idx[ADDR_W-1:0];
            default:              addr_c = addr_q;
        endcase
    end

    assign ram.ram_addr = addr_c;
    assign ram.ram_data = byte_q;
    assign ram.ram_wren = (state == S_WR) && !abort;

    assign busy  = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign done  = (state == S_DONE);
    assign error = (state == S_FAIL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            base     <= '0;
            addr_q   <= '0;
            byte_q   <= '0;
            idx      <= '0;
            end_pend <= 1'b0;
            count    <= '0;
            overrun  <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_c;
            if (latch_start) begin
                base    <= start_addr;
                count   <= '0;
                overrun <= 1'b0;
            end
            if (take_byte) byte_q <= data_in;
            if (do_write)  count  <= count + 1'b1;
            if (ovr_set)   overrun <= 1'b1;
            if (clr_pend || latch_start) begin
                end_pend <= 1'b0;
            end else if (set_pend) begin
                end_pend <= 1'b1;
            end
            if (start_rd) begin
                idx <= '0;
            end else if (acc) begin
                idx <= idx + 1'b1;
            end
        end
    end

    byte_checksum #(.W(DATA_W)) u_wsum (
        .clk    (clk),
        .reset  (reset),
        .clr    (latch_start),
        .add_en (do_write),
        .din    (byte_q),
        .sum    (wsum)
    );

    byte_checksum #(.W(DATA_W)) u_rsum (
        .clk    (clk),
        .reset  (reset),
        .clr    (start_rd),
        .add_en (acc),
        .din    (ram.ram_q),
        .sum    (rsum)
    );

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader. It uses a behavioural 256x8 RAM with a registered read address.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic       wr_strobe = 1'b0;
    logic [7:0] data_in = '0;
    logic       end_load = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] count;
    logic       busy, full, done, error, overrun;

    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [7:0] poke_dat = '0;
    logic [7:0] mem [0:255];
    int         wren_cnt = 0;

    int checks = 0;
    int errors = 0;

    ram_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .wr_strobe  (wr_strobe),
        .data_in    (data_in),
        .end_load   (end_load),
        .abort      (abort),
        .ram        (bus),
        .count      (count),
        .busy       (busy),
        .full       (full),
        .done       (done),
        .error      (error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        if (poke_en)      mem[poke_addr]    <= poke_dat;
        bus.ram_q <= mem[bus.ram_addr];
    end

    always @(posedge clk) begin
        if (bus.ram_wren) wren_cnt <= wren_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [7:0] a);
        start = 1'b1; start_addr = a;
        tick();
        start = 1'b0; start_addr = 8'h5A;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_strobe = 1'b1; data_in = d;
        tick();
        wr_strobe = 1'b0; data_in = 8'hC3;
        tick();
    endtask

    task automatic do_end();
        end_load = 1'b1;
        tick();
        end_load = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_dat = d;
        tick();
        poke_en = 1'b0;
    endtask

    initial begin
        int w0;
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // 1) base 10, three bytes, verify takes 10 cycles
        do_start(8'h10);
        chk("t1_busy", busy, 1);
        wr_byte(8'hA1); wr_byte(8'h02); wr_byte(8'h33);
        chk("t1_count", count, 3);
        chk("t1_mem10", mem[8'h10], 8'hA1);
        chk("t1_mem11", mem[8'h11], 8'h02);
        chk("t1_mem12", mem[8'h12], 8'h33);
        do_end();
        tick(9);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_addr_hold", bus.ram_addr, 8'h12);

        // 2) address wrap; last write shares its cycle with end_load
        do_start(8'hFE);
        wr_byte(8'h11); wr_byte(8'h22);
        wr_strobe = 1'b1; end_load = 1'b1; data_in = 8'h33;
        tick();
        wr_strobe = 1'b0; end_load = 1'b0;
        tick();
        chk("t2_still_load", busy, 1);
        tick();
        tick(9);
        chk("t2_done_early", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_memFE", mem[8'hFE], 8'h11);
        chk("t2_memFF", mem[8'hFF], 8'h22);
        chk("t2_mem00", mem[8'h00], 8'h33);
        chk("t2_count", count, 3);

        // 3) corrupted RAM
        do_start(8'h40);
        wr_byte(8'h05); wr_byte(8'h06);
        poke(8'h41, 8'h07);
        do_end();
        tick(7);
        chk("t3_error", error, 1);
        chk("t3_done", done, 0);

        // 4) empty load
        w0 = wren_cnt;
        do_start(8'h80);
        do_end();
        chk("t4_done", done, 1);
        chk("t4_count", count, 0);
        chk("t4_no_wren", wren_cnt, w0);

        // 5) fill the whole RAM, then overrun
        do_start(8'h00);
        for (int i = 0; i < 256; i++) wr_byte(i[7:0]);
        chk("t5_count", count, 9'h100);
        chk("t5_full", full, 1);
        chk("t5_ovr_clear", overrun, 0);
        wr_strobe = 1'b1; data_in = 8'hEE;
        tick();
        wr_strobe = 1'b0;
        tick();
        chk("t5_overrun", overrun, 1);
        chk("t5_count_hold", count, 9'h100);
        chk("t5_mem0", mem[8'h00], 8'h00);
        chk("t5_mem80", mem[8'h80], 8'h80);
        do_end();
        tick(769);
        chk("t5_done", done, 1);

        // Strobe during WR is dropped and flagged; start clears overrun
        do_start(8'h30);
        chk("wr_ovr_clear", overrun, 0);
        wr_strobe = 1'b1; data_in = 8'h01;
        tick();
        data_in = 8'h02;
        tick();
        wr_strobe = 1'b0;
        chk("wr_ovr_set", overrun, 1);
        chk("wr_ovr_count", count, 1);
        chk("wr_ovr_mem", mem[8'h30], 8'h01);

        // 6) abort during WR
        abort = 1'b1; tick(); abort = 1'b0;
        poke(8'h21, 8'h5A);
        do_start(8'h20);
        wr_byte(8'h44);
        wr_strobe = 1'b1; data_in = 8'h77;
        tick();
        wr_strobe = 1'b0;
        chk("t6_wr_state_wren", bus.ram_wren, 1);
        abort = 1'b1;
        #1;
        chk("t6_abort_wren", bus.ram_wren, 0);
        tick();
        abort = 1'b0;
        chk("t6_idle", busy, 0);
        chk("t6_count_kept", count, 1);
        chk("t6_mem21", mem[8'h21], 8'h5A);
        chk("t6_mem20", mem[8'h20], 8'h44);

        // Reset during verify
        do_start(8'h60);
        wr_byte(8'hAA); wr_byte(8'hBB);
        do_end();
        tick(2);
        chk("t6_verifying", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6r_busy", busy, 0);
        chk("t6r_count", count, 0);
        chk("t6r_addr", bus.ram_addr, 0);
        chk("t6r_data", bus.ram_data, 0);
        chk("t6r_wren", bus.ram_wren, 0);
        chk("t6r_flags", {full, done, error, overrun}, 4'b0000);
        tick();
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
